// File: rtl/lcd_text_ctrl.sv
// lcd_text_ctrl: ROWS x COLS HD44780 text sequencer feeding a byte-level I2C writer.
// Build option LCD_AUTO_REFRESH_EN: rewrite only rows whose text differs from the displayed text.
module lcd_text_ctrl #(
  parameter int unsigned ROWS     = 2,
  parameter int unsigned COLS     = 16,
  parameter int unsigned PWR_WAIT = 50000,
  parameter int unsigned CLR_WAIT = 2000
) (
  input  logic                   clk_1MHz,
  input  logic                   rst,
  input  logic                   ena,
  input  logic                   refresh,
  input  logic [ROWS*COLS*8-1:0] row_data,
  input  logic                   done_write,
  output logic [7:0]             data,
  output logic                   cmd_data,
  output logic                   ena_write,
  output logic                   busy,
  output logic                   init_done
);

  localparam int unsigned TXT_W    = ROWS * COLS * 8;
  localparam int unsigned ROW_W    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned WAIT_MAX = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int unsigned CNT_W    = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

  localparam logic [2:0] S_POWERUP    = 3'd0;
  localparam logic [2:0] S_INIT       = 3'd1;
  localparam logic [2:0] S_CLEAR_WAIT = 3'd2;
  localparam logic [2:0] S_IDLE       = 3'd3;
  localparam logic [2:0] S_LOAD       = 3'd4;
  localparam logic [2:0] S_SET_ADDR   = 3'd5;
  localparam logic [2:0] S_WR_CHAR    = 3'd6;
  localparam logic [2:0] S_WAIT_ACK   = 3'd7;

  logic [2:0]       state, state_nxt, ret_state, ret_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       init_idx, init_idx_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic             pending, pending_nxt;
  logic [TXT_W-1:0] shadow, shadow_nxt;
  logic [7:0]       data_nxt;
  logic             cmd_data_nxt, ena_write_nxt, busy_nxt, init_done_nxt;
  logic [ROWS-1:0]  frame_mask, load_mask;
  logic [ROW_W:0]   row_first, row_next;
  logic [7:0]       cur_char;
  int unsigned      char_pos;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    init_cmd = 8'h33;
      3'd1:    init_cmd = 8'h32;
      3'd2:    init_cmd = 8'h28;
      3'd3:    init_cmd = 8'h0C;
      3'd4:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] row_addr(input logic [ROW_W-1:0] r);
    case (32'(r))
      0:       row_addr = 8'h80;
      1:       row_addr = 8'hC0;
      2:       row_addr = 8'(32'h80 + COLS);
      default: row_addr = 8'(32'hC0 + COLS);
    endcase
  endfunction

  // Lowest row >= from that is set in mask; MSB flags that one was found.
  function automatic logic [ROW_W:0] find_row(input logic [ROWS-1:0] mask, input int unsigned from);
    logic found;
    found    = 1'b0;
    find_row = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!found && mask[r] && (r >= from)) begin
        found    = 1'b1;
        find_row = {1'b1, ROW_W'(r)};
      end
    end
  endfunction

`ifdef LCD_AUTO_REFRESH_EN
  localparam int unsigned ROW_BITS = COLS * 8;

  logic [ROWS-1:0] dirty, dirty_nxt, frame_mask_nxt, row_diff;

  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++)
      row_diff[r] = (row_data[(ROWS-1-r)*ROW_BITS +: ROW_BITS] != shadow[(ROWS-1-r)*ROW_BITS +: ROW_BITS]);
  end

  // A row goes out if it was marked dirty or differs from the text being snapshotted now.
  assign load_mask = dirty | row_diff;
`else
  assign load_mask  = '1;
  assign frame_mask = '1;
`endif

  assign row_first = find_row(load_mask, 0);
  assign row_next  = find_row(frame_mask, 32'(row) + 1);

  // Row 0 char 0 sits in the top byte of the shadow buffer.
  always_comb begin
    char_pos = (ROWS * COLS - 1) - (32'(row) * COLS + 32'(col));
    cur_char = 8'(shadow >> (char_pos * 8));
  end

  always_comb begin
    state_nxt     = state;
    ret_nxt       = ret_state;
    cnt_nxt       = cnt;
    init_idx_nxt  = init_idx;
    row_nxt       = row;
    col_nxt       = col;
    pending_nxt   = pending;
    shadow_nxt    = shadow;
    data_nxt      = data;
    cmd_data_nxt  = cmd_data;
    ena_write_nxt = 1'b0;
    init_done_nxt = init_done;
`ifdef LCD_AUTO_REFRESH_EN
    dirty_nxt      = dirty;
    frame_mask_nxt = frame_mask;
`endif

    case (state)
      S_POWERUP: begin
        if (cnt != CNT_W'(PWR_WAIT)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else if (ena) begin
          cnt_nxt   = '0;
          state_nxt = S_INIT;
        end
      end
      S_INIT: begin
        data_nxt      = init_cmd(init_idx);
        cmd_data_nxt  = 1'b0;
        ena_write_nxt = 1'b1;
        state_nxt     = S_WAIT_ACK;
        if (init_idx == 3'd5) begin
          init_idx_nxt = '0;
          ret_nxt      = S_CLEAR_WAIT;
        end else begin
          init_idx_nxt = init_idx + 3'd1;
          ret_nxt      = S_INIT;
        end
      end
      S_CLEAR_WAIT: begin
        if (cnt != CNT_W'(CLR_WAIT)) begin
          cnt_nxt = cnt + CNT_W'(1);
        end else begin
          cnt_nxt       = '0;
          init_done_nxt = 1'b1;
          pending_nxt   = 1'b1;
          state_nxt     = S_IDLE;
`ifdef LCD_AUTO_REFRESH_EN
          dirty_nxt     = '1;
`endif
        end
      end
      S_IDLE: begin
`ifdef LCD_AUTO_REFRESH_EN
        if (ena && (pending || (|dirty))) state_nxt = S_LOAD;
`else
        if (ena && pending) state_nxt = S_LOAD;
`endif
      end
      S_LOAD: begin
        shadow_nxt  = row_data;
        pending_nxt = 1'b0;
        col_nxt     = '0;
        row_nxt     = row_first[ROW_W-1:0];
        state_nxt   = row_first[ROW_W] ? S_SET_ADDR : S_IDLE;
`ifdef LCD_AUTO_REFRESH_EN
        frame_mask_nxt = load_mask;
`endif
      end
      S_SET_ADDR: begin
        data_nxt      = row_addr(row);
        cmd_data_nxt  = 1'b0;
        ena_write_nxt = 1'b1;
        ret_nxt       = S_WR_CHAR;
        state_nxt     = S_WAIT_ACK;
      end
      S_WR_CHAR: begin
        data_nxt      = cur_char;
        cmd_data_nxt  = 1'b1;
        ena_write_nxt = 1'b1;
        state_nxt     = S_WAIT_ACK;
        if (col == COL_W'(COLS - 1)) begin
          col_nxt = '0;
          if (row_next[ROW_W]) begin
            row_nxt = row_next[ROW_W-1:0];
            ret_nxt = S_SET_ADDR;
          end else begin
            ret_nxt = S_IDLE;
          end
        end else begin
          col_nxt = col + COL_W'(1);
          ret_nxt = S_WR_CHAR;
        end
      end
      S_WAIT_ACK: begin
        if (done_write) state_nxt = ret_state;
      end
      default: state_nxt = S_POWERUP;
    endcase

    // Refresh overrides the clear done by LOAD so a coincident request is not lost.
`ifdef LCD_AUTO_REFRESH_EN
    if (state == S_IDLE && init_done) dirty_nxt = dirty | row_diff;
    if (state == S_LOAD)              dirty_nxt = '0;
    if (refresh)                      dirty_nxt = '1;
`endif
    if (refresh) pending_nxt = 1'b1;

    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      state     <= S_POWERUP;
      ret_state <= S_POWERUP;
      cnt       <= '0;
      init_idx  <= '0;
      row       <= '0;
      col       <= '0;
      pending   <= 1'b0;
      shadow    <= '0;
      data      <= 8'h00;
      cmd_data  <= 1'b0;
      ena_write <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      cnt       <= cnt_nxt;
      init_idx  <= init_idx_nxt;
      row       <= row_nxt;
      col       <= col_nxt;
      pending   <= pending_nxt;
      shadow    <= shadow_nxt;
      data      <= data_nxt;
      cmd_data  <= cmd_data_nxt;
      ena_write <= ena_write_nxt;
      busy      <= busy_nxt;
      init_done <= init_done_nxt;
    end
  end

`ifdef LCD_AUTO_REFRESH_EN
  always_ff @(posedge clk_1MHz or posedge rst) begin
    if (rst) begin
      dirty      <= '0;
      frame_mask <= '0;
    end else begin
      dirty      <= dirty_nxt;
      frame_mask <= frame_mask_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: writer model, byte scoreboard, init/frame/refresh/reset sequences.
// With LCD_AUTO_REFRESH_EN defined it runs a 4x20 display and adds the dirty-row case.
`timescale 1ns/1ps
module tb_lcd_text_ctrl;

`ifdef LCD_AUTO_REFRESH_EN
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 20;
`else
  localparam int unsigned ROWS = 2;
  localparam int unsigned COLS = 16;
`endif
  localparam int unsigned PWR_WAIT    = 100;
  localparam int unsigned CLR_WAIT    = 20;
  localparam int unsigned TXT_W       = ROWS * COLS * 8;
  localparam int unsigned FRAME_BYTES = ROWS * (1 + COLS);

  logic             clk_1MHz = 1'b0;
  logic             rst, ena, refresh, done_write;
  logic [TXT_W-1:0] row_data;
  logic [7:0]       data;
  logic             cmd_data, ena_write, busy, init_done;

  lcd_text_ctrl #(.ROWS(ROWS), .COLS(COLS), .PWR_WAIT(PWR_WAIT), .CLR_WAIT(CLR_WAIT)) dut (
    .clk_1MHz   (clk_1MHz),
    .rst        (rst),
    .ena        (ena),
    .refresh    (refresh),
    .row_data   (row_data),
    .done_write (done_write),
    .data       (data),
    .cmd_data   (cmd_data),
    .ena_write  (ena_write),
    .busy       (busy),
    .init_done  (init_done)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  typedef struct packed {
    logic       cmd;
    logic [7:0] val;
  } lcd_byte_t;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } vec_t;

  lcd_byte_t exp_q[$];
  vec_t      init_tab[6];
  vec_t      rst_tab[5];

  int n_tests = 0;
  int n_fail  = 0;
  int bytes_seen = 0;
  bit saw_ena = 1'b0;
  int ack_delay = 5;
  int ack_cnt = 0;
  bit stray_req = 1'b0;

  logic [TXT_W-1:0] text_a, text_b, text_c;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] txt_char(input logic [TXT_W-1:0] t, input int unsigned r, input int unsigned c);
    return t[(ROWS*COLS-1-(r*COLS+c))*8 +: 8];
  endfunction

  function automatic logic [7:0] row_cmd(input int unsigned r);
    case (r)
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'(32'h80 + COLS);
      default: return 8'(32'hC0 + COLS);
    endcase
  endfunction

  function automatic logic [TXT_W-1:0] set_row(input logic [TXT_W-1:0] t, input int unsigned r, input int unsigned seed);
    logic [TXT_W-1:0] o;
    o = t;
    for (int unsigned c = 0; c < COLS; c++)
      o[(ROWS*COLS-1-(r*COLS+c))*8 +: 8] = 8'(32'h21 + (seed + r*7 + c*3) % 90);
    return o;
  endfunction

  function automatic logic [TXT_W-1:0] make_text(input int unsigned seed);
    logic [TXT_W-1:0] o;
    o = '0;
    for (int unsigned r = 0; r < ROWS; r++) o = set_row(o, r, seed);
    return o;
  endfunction

  task automatic push_init();
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, init_tab[i].exp});
  endtask

  task automatic push_frame(input logic [TXT_W-1:0] t, input logic [3:0] mask);
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (mask[r]) begin
        exp_q.push_back({1'b0, row_cmd(r)});
        for (int unsigned c = 0; c < COLS; c++) exp_q.push_back({1'b1, txt_char(t, r, c)});
      end
    end
  endtask

  // One clock: sample outputs at the falling edge, score bytes, run the writer model.
  task automatic step();
    lcd_byte_t e;
    @(negedge clk_1MHz);
    saw_ena = ena_write;
    if (ena_write) begin
      bytes_seen++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got cmd=%0b data=0x%02h required no byte", cmd_data, data);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("byte%0d", bytes_seen), 32'({cmd_data, data}), 32'({e.cmd, e.val}));
      end
    end
    done_write = 1'b0;
    if (rst) begin
      ack_cnt = 0;
    end else begin
      if (ack_cnt != 0) begin
        ack_cnt--;
        if (ack_cnt == 0) done_write = 1'b1;
      end
      if (ena_write) ack_cnt = ack_delay;
    end
    if (stray_req) begin
      done_write = 1'b1;
      stray_req  = 1'b0;
    end
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    step();
    refresh = 1'b0;
  endtask

  task automatic wait_bytes(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (bytes_seen < target && n < budget) begin
      step();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check({name, "_done"}, 32'(n < budget), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    logic [7:0] got;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       got = 8'(ena_write);
        1:       got = data;
        2:       got = 8'(cmd_data);
        3:       got = 8'(busy);
        default: got = 8'(init_done);
      endcase
      check({tag, "_", rst_tab[i].name}, 32'(got), 32'(rst_tab[i].exp));
    end
  endtask

  initial begin
    int n, base;
    logic [7:0] hold_d;
    logic       hold_c;
    int viol;

    init_tab[0] = '{"init0", 8'h33};
    init_tab[1] = '{"init1", 8'h32};
    init_tab[2] = '{"init2", 8'h28};
    init_tab[3] = '{"init3", 8'h0C};
    init_tab[4] = '{"init4", 8'h06};
    init_tab[5] = '{"init5", 8'h01};
    rst_tab[0]  = '{"ena_write", 8'h00};
    rst_tab[1]  = '{"data",      8'h00};
    rst_tab[2]  = '{"cmd_data",  8'h00};
    rst_tab[3]  = '{"busy",      8'h01};
    rst_tab[4]  = '{"init_done", 8'h00};

`ifdef LCD_AUTO_REFRESH_EN
    text_a = make_text(1);
`else
    text_a = {"  FPT Jetking   ", "  Chip Design   "};
`endif
    text_b = make_text(5);

    rst = 1'b1; ena = 1'b1; refresh = 1'b0; done_write = 1'b0; row_data = text_a;
    repeat (3) step();
    check_reset("por");
    rst = 1'b0;

    // Init sequence, clear wait, first frame; three refreshes during it add one frame.
    push_init();
    push_frame(text_a, 4'hF);
    n = 0;
    while (!(saw_ena && data == 8'h01 && !cmd_data) && n < 2000) begin
      step();
      n++;
    end
    check("clear_cmd_seen", 32'(n < 2000), 32'd1);
    check("init_done_low_at_clear", 32'(init_done), 32'd0);
    n = 0;
    while (!init_done && n < 200) begin
      step();
      n++;
    end
    check("clear_wait_min", 32'(n >= CLR_WAIT + 5), 32'd1);
    check("clear_wait_max", 32'(n <= CLR_WAIT + 10), 32'd1);
    wait_bytes(6 + 3, 500, "frame1_started");
    pulse_refresh();
    repeat (7) step();
    pulse_refresh();
    repeat (11) step();
    pulse_refresh();
    push_frame(text_a, 4'hF);
    wait_idle(4000, "frames_1_2");
    check("busy_low_idle", 32'(busy), 32'd0);
    check("init_done_set", 32'(init_done), 32'd1);
    repeat (100) step();
    check("byte_count_init_2frames", 32'(bytes_seen), 32'(6 + 2 * FRAME_BYTES));

    // Text change at char 5 of row 0: current frame keeps old text, next shows new.
    base = bytes_seen;
    push_frame(text_a, 4'hF);
    pulse_refresh();
    wait_bytes(base + 7, 500, "char5_reached");
    row_data = text_b;
    pulse_refresh();
    push_frame(text_b, 4'hF);
    wait_idle(4000, "text_change");

    // ena low holds the request in IDLE until ena returns.
    ena = 1'b0;
    base = bytes_seen;
    pulse_refresh();
    repeat (50) step();
    check("ena_low_idle", 32'(busy), 32'd0);
    check("ena_low_no_bytes", 32'(bytes_seen), 32'(base));
    push_frame(text_b, 4'hF);
    ena = 1'b1;
    wait_idle(4000, "ena_release");

    // Writer holds done_write off for 200 cycles.
    ack_delay = 200;
    push_frame(text_b, 4'hF);
    pulse_refresh();
    n = 0;
    while (!saw_ena && n < 100) begin
      step();
      n++;
    end
    check("slow_ack_started", 32'(saw_ena), 32'd1);
    hold_d = data;
    hold_c = cmd_data;
    viol = 0;
    repeat (199) begin
      step();
      if (saw_ena || data !== hold_d || cmd_data !== hold_c) viol++;
    end
    check("slow_ack_hold", 32'(viol), 32'd0);
    ack_delay = 5;
    wait_idle(4000, "slow_ack");

    // Reset while waiting for the ack of row 0 char 7, then a stray done_write.
    ack_delay = 30;
    base = bytes_seen;
    push_frame(text_b, 4'hF);
    pulse_refresh();
    wait_bytes(base + 9, 1000, "char7_reached");
    check("char7_ena_seen", 32'(saw_ena), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_reset("async_rst");
    exp_q.delete();
    repeat (3) step();
    rst = 1'b0;
    ack_delay = 5;
    push_init();
    push_frame(text_b, 4'hF);
    n = 0;
    step();
    step();
    n = 2;
    stray_req = 1'b1;
    while (!saw_ena && n < int'(PWR_WAIT) + 50) begin
      step();
      n++;
    end
    check("pwr_wait_min", 32'(n >= PWR_WAIT), 32'd1);
    check("pwr_wait_max", 32'(n <= PWR_WAIT + 5), 32'd1);
    wait_idle(6000, "restart");

`ifdef LCD_AUTO_REFRESH_EN
    // Only row 2 changes: one row rewrite, then nothing further.
    base = bytes_seen;
    text_c = set_row(text_b, 2, 9);
    row_data = text_c;
    push_frame(text_c, 4'b0100);
    wait_idle(2000, "dirty_row2");
    repeat (200) step();
    check("dirty_row2_bytes", 32'(bytes_seen - base), 32'(1 + COLS));
    check("dirty_row2_idle", 32'(busy), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
